// File: rtl/peripheral_responder.sv
// -----------------------------------------------------------------------------
// peripheral_responder
//
// Memory-mapped peripheral block in a 32-byte window at BASE_ADDR. It holds a
// reloading timer with an interrupt, an 8-bit LED register, a 12-bit
// seven-segment register and an optional free-running SYSTICK counter.
//
// Register map (word offsets, Address[4:2]):
//   0x00 TH      timer reload value
//   0x04 TL      timer count
//   0x08 TCON    {29'b0, status, irq_en, enable}
//   0x0C LED     8-bit LED register
//   0x10 DIGI    12-bit seven-segment register (11:8 anodes, 7:0 segments)
//   0x14 SYSTICK free-running counter (read-only); reads 0 when not built
//
// Build option: define PERIPH_SYSTICK_EN to include the SYSTICK counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   Address    CPU byte address
//   MemRead    read strobe
//   MemWrite   write strobe
//   Write_data store data
//   Read_data  combinational load data (0 unless MemRead and Hit)
//   Hit        combinational decode of a mapped, word-aligned register
//   Irq        timer interrupt request (status AND irq_en)
//   led        LED register
//   digi       seven-segment register
// -----------------------------------------------------------------------------
module peripheral_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        Hit,
  output logic        Irq,
  output logic [7:0]  led,
  output logic [11:0] digi
);

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGI    = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  logic [31:0] th_q,   th_d;
  logic [31:0] tl_q,   tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [7:0]  led_q,  led_d;
  logic [11:0] digi_q, digi_d;
  logic        irq_q,  irq_d;

  logic [2:0]  offset_s;
  logic        window_s;
  logic        wr_s;
  logic        reload_s;
  logic [31:0] systick_rd_s;

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick_q, systick_d;

  // SYSTICK free-runs and wraps naturally; software writes are ignored.
  always_comb begin
    systick_d    = systick_q + 32'd1;
    systick_rd_s = systick_q;
  end

  // SYSTICK counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      systick_q <= 32'h0;
    end else begin
      systick_q <= systick_d;
    end
  end
`else
  // No SYSTICK counter: the offset still decodes and reads as zero.
  always_comb begin
    systick_rd_s = 32'h0;
  end
`endif

  // Address decode: window match, word alignment and mapped offset range.
  always_comb begin
    offset_s = Address[4:2];
    window_s = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
    Hit      = window_s && (offset_s <= OFF_SYSTICK);
    wr_s     = MemWrite && Hit;
  end

  // Read mux; reflects current register values so a same-cycle write
  // returns the pre-write value.
  always_comb begin
    Read_data = 32'h0;
    if (MemRead && Hit) begin
      case (offset_s)
        OFF_TH:      Read_data = th_q;
        OFF_TL:      Read_data = tl_q;
        OFF_TCON:    Read_data = {29'h0, tcon_q};
        OFF_LED:     Read_data = {24'h0, led_q};
        OFF_DIGI:    Read_data = {20'h0, digi_q};
        OFF_SYSTICK: Read_data = systick_rd_s;
        default:     Read_data = 32'h0;
      endcase
    end else begin
      Read_data = 32'h0;
    end
  end

  // Next-state for timer, control and output registers.
  always_comb begin
    th_d     = th_q;
    tl_d     = tl_q;
    tcon_d   = tcon_q;
    led_d    = led_q;
    digi_d   = digi_q;
    reload_s = 1'b0;

    // Timer advance uses the current enable, so clearing enable via a write
    // still lets this edge count and stops from the next one.
    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d     = th_q;
        reload_s = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end else begin
      tl_d = tl_q;
    end

    if (wr_s) begin
      case (offset_s)
        OFF_TH:   th_d   = Write_data;
        OFF_TL: begin
          // CPU write wins over the timer; the overridden reload is dropped.
          tl_d     = Write_data;
          reload_s = 1'b0;
        end
        OFF_TCON: tcon_d = Write_data[2:0];
        OFF_LED:  led_d  = Write_data[7:0];
        OFF_DIGI: digi_d = Write_data[11:0];
        default:  th_d   = th_q;
      endcase
    end else begin
      th_d = th_q;
    end

    // Reload status set is applied last so it beats a same-cycle clear.
    if (reload_s && tcon_q[1]) begin
      tcon_d[2] = 1'b1;
    end else begin
      tcon_d[2] = tcon_d[2];
    end

    irq_d = tcon_d[2] & tcon_d[1];
  end

  // Register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= 32'h0;
      tl_q   <= 32'h0;
      tcon_q <= 3'h0;
      led_q  <= 8'h00;
      digi_q <= 12'h000;
      irq_q  <= 1'b0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      led_q  <= led_d;
      digi_q <= digi_d;
      irq_q  <= irq_d;
    end
  end

  assign Irq  = irq_q;
  assign led  = led_q;
  assign digi = digi_q;

endmodule
